// File: rtl/pc_sequencer.sv
// Fetch program-counter stage. It holds the fetch PC and picks between PC+4 and a resolved
// branch or jump target. It issues fetch requests over a valid/ready handshake and buffers one
// redirect that arrives while a request is outstanding. A misaligned target is trapped to a
// fixed vector.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'hBFC0_0100
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iPCTarget,
  input  logic        iFetchReady,
  output logic        oFetchValid,
  output logic [31:0] oPC,
  output logic [31:0] oPCPlus4,
  output logic        oRedirectPending,
  output logic        oMisalign
);

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        valid_q, valid_d;
  logic        pending_q, pending_d;

  logic        accept;
  logic        issue_next;
  logic        load_en;
  logic [31:0] load_addr;

  // Handshake completes when a valid request meets a ready memory.
  always_comb begin
    accept = valid_q & iFetchReady;
  end

  // Next-state, next-PC and redirect buffering.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    pending_d     = pending_q;
    pend_target_d = pend_target_q;
    load_en       = 1'b0;
    load_addr     = pc_q;
    // An outstanding request holds regardless of iStall; otherwise a stall blocks a new issue.
    issue_next    = (~valid_q | accept) ? ~iStall : 1'b1;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        valid_d = ~iStall;
        if (iRedirect) begin
          load_en   = 1'b1;
          load_addr = iPCTarget;
        end
      end
      StTrap: begin
        state_d = StFetch;
        valid_d = ~iStall;
      end
      StFetch: begin
        valid_d = issue_next;
        if (iRedirect && (accept || !valid_q)) begin
          // A fresh redirect supersedes any buffered one.
          load_en   = 1'b1;
          load_addr = iPCTarget;
          pending_d = 1'b0;
        end else if (iRedirect) begin
          // Request still outstanding: park the latest target until the accept.
          pend_target_d = iPCTarget;
          pending_d     = 1'b1;
        end else if (pending_q && accept) begin
          load_en   = 1'b1;
          load_addr = pend_target_q;
          pending_d = 1'b0;
        end else if (accept) begin
          pc_d = pc_q + 32'd4;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    // Alignment is only checked at the moment a target is applied to the PC.
    if (load_en) begin
      if (load_addr[1:0] != 2'b00) begin
        pc_d      = TRAP_VECTOR;
        state_d   = StTrap;
        valid_d   = 1'b0;
        pending_d = 1'b0;
      end else begin
        pc_d = load_addr;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      valid_q       <= 1'b0;
      pending_q     <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      pending_q     <= pending_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Outputs come straight from registers, except the PC+4 adder.
  always_comb begin
    oPC              = pc_q;
    oPCPlus4         = pc_q + 32'd4;
    oFetchValid      = valid_q;
    oRedirectPending = pending_q;
    oMisalign        = (state_q == StTrap);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes expected status and fetch addresses from
// a behavioural model; a negedge monitor pops and compares.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] TV = 32'hBFC0_0100;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iPCTarget;
  logic        iFetchReady;
  logic        oFetchValid;
  logic [31:0] oPC;
  logic [31:0] oPCPlus4;
  logic        oRedirectPending;
  logic        oMisalign;

  pc_sequencer dut (
    .iClk            (iClk),
    .iRst            (iRst),
    .iStall          (iStall),
    .iRedirect       (iRedirect),
    .iPCTarget       (iPCTarget),
    .iFetchReady     (iFetchReady),
    .oFetchValid     (oFetchValid),
    .oPC             (oPC),
    .oPCPlus4        (oPCPlus4),
    .oRedirectPending(oRedirectPending),
    .oMisalign       (oMisalign)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } status_t;

  status_t     exp_q[$];
  logic [31:0] fetch_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  bit          m_valid, m_pend, m_boot, m_trap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_ptgt = 32'h0; m_valid = 0; m_pend = 0; m_boot = 1; m_trap = 0;
  endtask

  // Apply a target to the PC; misaligned targets divert to the trap vector.
  task automatic model_load(input logic [31:0] a);
    if (a % 4 != 0) begin
      m_pc = TV; m_trap = 1; m_valid = 0; m_pend = 0;
    end else begin
      m_pc = a;
    end
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] tg, input bit rdy);
    bit acc;
    bit nvalid;
    acc = m_valid && rdy;
    if (m_trap) begin
      m_trap = 0; m_valid = !st;
    end else if (m_boot) begin
      m_boot = 0; m_valid = !st;
      if (rd) model_load(tg);
    end else begin
      nvalid = (!m_valid || acc) ? !st : 1'b1;
      if (rd && (acc || !m_valid)) begin
        m_pend = 0; m_valid = nvalid; model_load(tg);
      end else if (rd) begin
        m_ptgt = tg; m_pend = 1;
      end else if (m_pend && acc) begin
        m_pend = 0; m_valid = nvalid; model_load(m_ptgt);
      end else begin
        if (acc) m_pc = m_pc + 32'd4;
        m_valid = nvalid;
      end
    end
  endtask

  // One clock of stimulus; expected values are queued before the edge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] tg, input bit rdy);
    status_t s;
    iStall = st; iRedirect = rd; iPCTarget = tg; iFetchReady = rdy;
    s.pc = m_pc; s.valid = m_valid; s.pend = m_pend; s.mis = m_trap;
    exp_q.push_back(s);
    if (m_valid && rdy) fetch_q.push_back(m_pc);
    @(posedge iClk);
    model_step(st, rd, tg, rdy);
    #1;
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  always @(negedge iClk) begin
    status_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL status_queue: got empty expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("pc", oPC, e.pc);
        check("pc_plus4", oPCPlus4, e.pc + 32'd4);
        check("fetch_valid", {31'h0, oFetchValid}, {31'h0, e.valid});
        check("redirect_pending", {31'h0, oRedirectPending}, {31'h0, e.pend});
        check("misalign", {31'h0, oMisalign}, {31'h0, e.mis});
        if (oFetchValid && iFetchReady) begin
          if (fetch_q.size() == 0) begin
            total++; bad++;
            $display("FAIL fetch_queue: got accept at %h expected none at %0t", oPC, $time);
          end else begin
            check("fetch_addr", oPC, fetch_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tg;
    int r;
    iRst = 1'b1; iStall = 0; iRedirect = 0; iPCTarget = 0; iFetchReady = 0;
    model_reset();
    repeat (3) @(posedge iClk);
    #1;
    check("reset_pc", oPC, RV);
    check("reset_valid", {31'h0, oFetchValid}, 32'h0);
    check("reset_pending", {31'h0, oRedirectPending}, 32'h0);
    check("reset_misalign", {31'h0, oMisalign}, 32'h0);
    iRst = 1'b0;
    mon_en = 1'b1;

    // Boot, then sequential fetch.
    repeat (4) cycle(0, 0, 32'h0, 1);
    // Outstanding request held through stall and not-ready.
    repeat (3) cycle(1, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    // Buffered redirect, then two redirects while pending (latest wins).
    cycle(0, 1, 32'h0000_1000, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 1, 32'h0000_3000, 0);
    cycle(0, 1, 32'h0000_2000, 0);
    cycle(0, 0, 32'h0, 1);
    // Misaligned redirect on accept traps.
    cycle(0, 1, 32'h0000_1002, 1);
    repeat (3) cycle(0, 0, 32'h0, 1);
    // Wrap at top of address space; redirect beats PC+4.
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 1, 32'h0000_0040, 1);
    // Misaligned buffered target traps only when applied.
    cycle(0, 1, 32'h0000_0041, 0);
    cycle(0, 0, 32'h0, 0);
    repeat (3) cycle(0, 0, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(9);
      if (r == 0) tg = $urandom() | 32'h1;
      else if (r == 1) tg = 32'hFFFF_FFF8;
      else tg = $urandom() & 32'hFFFF_FFFC;
      cycle(($urandom_range(3) == 0), ($urandom_range(4) == 0), tg, ($urandom_range(2) != 0));
    end

    // Asynchronous reset with a redirect pending.
    repeat (3) cycle(0, 0, 32'h0, 0);
    cycle(0, 1, 32'h0000_0500, 0);
    mon_en = 1'b0;
    check("pre_reset_pending", {31'h0, oRedirectPending}, {31'h0, m_pend});
    #2;
    iRst = 1'b1;
    #1;
    check("async_reset_pc", oPC, RV);
    check("async_reset_valid", {31'h0, oFetchValid}, 32'h0);
    check("async_reset_pending", {31'h0, oRedirectPending}, 32'h0);
    check("async_reset_misalign", {31'h0, oMisalign}, 32'h0);
    exp_q.delete();
    fetch_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
